plc_sequence_timer: RTL

- Parametrised multi-phase PLC-style sequence timer.
- A debounced active-low push button starts a sequence of NUM_PHASES timed phases. Each phase drives a fixed NUM_OUT-bit GPIO pattern for a run-time-programmable number of clock cycles.
- Supports one-shot and repeat modes, retrigger and abort. Sits between board buttons/config registers and the GPIO pins.

---
 rtl/plc_timer_pkg.sv | 17 +
 rtl/plc_sequence_timer_btn_debounce.sv | 66 ++++++
 rtl/plc_sequence_timer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/plc_timer_pkg.sv
// Shared types and helpers for the PLC sequence timer.
package plc_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the phase index; at least one bit even for a single phase.
  function automatic int unsigned phase_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/plc_sequence_timer_btn_debounce.sv
// Two-flop synchroniser plus stability counter for a raw push button.
// Emits a registered one-cycle pulse one cycle after the debounced level falls.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter bit          RST_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall_pulse
);

  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RST_LEVEL;
      r_sync2 <= RST_LEVEL;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= RST_LEVEL;
      r_cnt   <= '0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered falling-edge detect on the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= RST_LEVEL;
      r_fall    <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_fall    <= r_level_d & ~r_level;
    end
  end

  assign level      = r_level;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/plc_sequence_timer.sv
// Multi-phase sequence timer: a debounced button press runs NUM_PHASES timed
// GPIO patterns, one-shot or repeating, with retrigger and abort.
module plc_sequence_timer
  import plc_timer_pkg::*;
#(
  parameter int unsigned                  NUM_OUT    = 2,
  parameter int unsigned                  NUM_PHASES = 3,
  parameter int unsigned                  CNT_W      = 32,
  parameter int unsigned                  DEB_CYCLES = 16,
  parameter logic [NUM_PHASES*NUM_OUT-1:0] PHASE_PAT = {2'b10, 2'b01, 2'b00}
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  btn,
  input  logic                                  abort,
  input  logic                                  repeat_en,
  input  logic [NUM_PHASES*CNT_W-1:0]           phase_len,
  output logic [NUM_OUT-1:0]                    gpio,
  output logic                                  busy,
  output logic [phase_width(NUM_PHASES)-1:0]    phase_idx,
  output logic [CNT_W-1:0]                      remaining,
  output logic                                  done
);

  localparam int unsigned   PW   = phase_width(NUM_PHASES);
  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);

  state_e                        r_state;
  logic [NUM_OUT-1:0]            r_gpio;
  logic                          r_busy;
  logic [PW-1:0]                 r_phase;
  logic [CNT_W-1:0]              r_rem;
  logic                          r_done;
  logic [NUM_PHASES*CNT_W-1:0]   r_len;

  state_e                        w_state;
  logic [NUM_OUT-1:0]            w_gpio;
  logic                          w_busy;
  logic [PW-1:0]                 w_phase;
  logic [PW-1:0]                 w_phase_nxt;
  logic [CNT_W-1:0]              w_rem;
  logic                          w_done;
  logic [NUM_PHASES*CNT_W-1:0]   w_len;
  logic                          w_btn_level;
  logic                          w_btn_fall;
  logic                          w_start;

  // Phase length lookup; a zero length runs for one cycle.
  function automatic logic [CNT_W-1:0] len_pick(input logic [NUM_PHASES*CNT_W-1:0] v,
                                                input logic [PW-1:0] idx);
    logic [CNT_W-1:0] l;
    l = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (idx == PW'(k)) l = v[k*CNT_W +: CNT_W];
    end
    return (l == '0) ? CNT_W'(1) : l;
  endfunction

  // Output pattern lookup for a phase.
  function automatic logic [NUM_OUT-1:0] pat_pick(input logic [PW-1:0] idx);
    logic [NUM_OUT-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (idx == PW'(k)) p = PHASE_PAT[k*NUM_OUT +: NUM_OUT];
    end
    return p;
  endfunction

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .RST_LEVEL  (1'b1)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (btn),
    .level      (w_btn_level),
    .fall_pulse (w_btn_fall)
  );

  // Press event, qualified by the settled low level.
  assign w_start = w_btn_fall & ~w_btn_level;

  // Next-state and next-output logic; abort beats start beats counting.
  always_comb begin
    w_state     = r_state;
    w_gpio      = r_gpio;
    w_busy      = r_busy;
    w_phase     = r_phase;
    w_rem       = r_rem;
    w_done      = 1'b0;
    w_len       = r_len;
    w_phase_nxt = r_phase + PW'(1);

    if (abort) begin
      w_state = IDLE;
      w_gpio  = '0;
      w_busy  = 1'b0;
      w_phase = '0;
      w_rem   = '0;
    end else if (w_start) begin
      w_state = RUN;
      w_len   = phase_len;
      w_phase = '0;
      w_rem   = len_pick(phase_len, '0);
      w_gpio  = pat_pick('0);
      w_busy  = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (r_rem > CNT_W'(1)) begin
            w_rem = r_rem - CNT_W'(1);
          end else if (r_phase == LAST) begin
            if (repeat_en) begin
              w_len   = phase_len;
              w_phase = '0;
              w_rem   = len_pick(phase_len, '0);
              w_gpio  = pat_pick('0);
            end else begin
              w_state = DONE;
              w_gpio  = '0;
              w_busy  = 1'b0;
              w_phase = '0;
              w_rem   = '0;
              w_done  = 1'b1;
            end
          end else begin
            w_phase = w_phase_nxt;
            w_rem   = len_pick(r_len, w_phase_nxt);
            w_gpio  = pat_pick(w_phase_nxt);
          end
        end
        default: begin
          w_state = IDLE;
          w_gpio  = '0;
          w_busy  = 1'b0;
          w_phase = '0;
          w_rem   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gpio  <= '0;
      r_busy  <= 1'b0;
      r_phase <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_state;
      r_gpio  <= w_gpio;
      r_busy  <= w_busy;
      r_phase <= w_phase;
      r_rem   <= w_rem;
      r_done  <= w_done;
      r_len   <= w_len;
    end
  end

  assign gpio      = r_gpio;
  assign busy      = r_busy;
  assign phase_idx = r_phase;
  assign remaining = r_rem;
  assign done      = r_done;

endmodule
